// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: bus widths,
// FSM state encoding and bus-owner encoding.
package mem_arbiter_pkg;

    localparam int DATA_BUS_WIDTH = 64;
    localparam int ADDR_WIDTH     = 64;
    localparam int MASK_WIDTH     = DATA_BUS_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between an instruction fetch
// unit (read-only) and a load/store unit. One access is in flight at a time;
// a stalled access is forced to complete with zero data after TIMEOUT_CYCLES
// idle cycles in WAIT.
//
// Ports
//   clk, rst              system clock, synchronous active-high reset
//   if_*                  IFU request / grant / response
//   ls_*                  LSU request (read or masked write) / grant / response
//   mem_*                 downstream memory request / grant / response
//   arb_busy_o            an access is in progress (state not IDLE)
//   arb_timeout_o         one-cycle pulse when an access is forced complete
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no access; arbitrate between requesters, grant combinationally
// ST_REQ  | mem_req_o asserted with latched fields until mem_gnt_i
// ST_WAIT | awaiting mem_rvalid_i; timeout counter running
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      if_req_i,
    input  logic [ADDR_WIDTH-1:0]     if_addr_i,
    output logic                      if_gnt_o,
    output logic                      if_rvalid_o,
    output logic [DATA_BUS_WIDTH-1:0] if_rdata_o,

    input  logic                      ls_req_i,
    input  logic                      ls_wen_i,
    input  logic [ADDR_WIDTH-1:0]     ls_addr_i,
    input  logic [DATA_BUS_WIDTH-1:0] ls_wdata_i,
    input  logic [MASK_WIDTH-1:0]     ls_wmask_i,
    output logic                      ls_gnt_o,
    output logic                      ls_rvalid_o,
    output logic [DATA_BUS_WIDTH-1:0] ls_rdata_o,

    output logic                      mem_req_o,
    output logic                      mem_wen_o,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic [DATA_BUS_WIDTH-1:0] mem_wdata_o,
    output logic [MASK_WIDTH-1:0]     mem_wmask_o,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    input  logic [DATA_BUS_WIDTH-1:0] mem_rdata_i,

    output logic                      arb_busy_o,
    output logic                      arb_timeout_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES);

    arb_state_e                state_q, state_d;
    owner_e                    owner_q, owner_d;   // current owner, doubles as last_owner
    logic                      wen_q,   wen_d;
    logic [ADDR_WIDTH-1:0]     addr_q,  addr_d;
    logic [DATA_BUS_WIDTH-1:0] wdata_q, wdata_d;
    logic [MASK_WIDTH-1:0]     wmask_q, wmask_d;
    logic [CNT_W-1:0]          cnt_q,   cnt_d;     // down-counter, terminal count at zero

    logic                      pick_lsu;
    logic                      rsp_vld;
    logic [DATA_BUS_WIDTH-1:0] rsp_data;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        wen_d         = wen_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        cnt_d         = cnt_q;
        pick_lsu      = 1'b0;
        rsp_vld       = 1'b0;
        rsp_data      = '0;
        if_gnt_o      = 1'b0;
        if_rvalid_o   = 1'b0;
        if_rdata_o    = '0;
        ls_gnt_o      = 1'b0;
        ls_rvalid_o   = 1'b0;
        ls_rdata_o    = '0;
        mem_req_o     = 1'b0;
        mem_wen_o     = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        mem_wmask_o   = '0;
        arb_busy_o    = 1'b0;
        arb_timeout_o = 1'b0;

        // Everything is held quiet while rst is high so an access cut off by
        // reset never produces a response or a grant.
        if (!rst) begin
            arb_busy_o = (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    // Under contention the requester that did not own the
                    // bus last time wins.
                    pick_lsu = ls_req_i && (!if_req_i || (owner_q == OWN_IFU));
                    if (pick_lsu) begin
                        ls_gnt_o = 1'b1;
                        owner_d  = OWN_LSU;
                        wen_d    = ls_wen_i;
                        addr_d   = ls_addr_i;
                        wdata_d  = ls_wdata_i;
                        wmask_d  = ls_wmask_i;
                        state_d  = ST_REQ;
                    end else if (if_req_i) begin
                        if_gnt_o = 1'b1;
                        owner_d  = OWN_IFU;
                        wen_d    = 1'b0;
                        addr_d   = if_addr_i;
                        wdata_d  = '0;
                        wmask_d  = '0;
                        state_d  = ST_REQ;
                    end
                end
                ST_REQ: begin
                    mem_req_o   = 1'b1;
                    mem_wen_o   = wen_q;
                    mem_addr_o  = addr_q;
                    mem_wdata_o = wdata_q;
                    mem_wmask_o = wmask_q;
                    if (mem_gnt_i) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
                ST_WAIT: begin
                    mem_wen_o   = wen_q;
                    mem_addr_o  = addr_q;
                    mem_wdata_o = wdata_q;
                    mem_wmask_o = wmask_q;
                    if (mem_rvalid_i) begin
                        rsp_vld  = 1'b1;
                        rsp_data = mem_rdata_i;
                        state_d  = ST_IDLE;
                    end else if (cnt_q == '0) begin
                        rsp_vld       = 1'b1;
                        arb_timeout_o = 1'b1;
                        state_d       = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (rsp_vld) begin
                if (owner_q == OWN_LSU) begin
                    ls_rvalid_o = 1'b1;
                    ls_rdata_o  = rsp_data;
                end else begin
                    if_rvalid_o = 1'b1;
                    if_rdata_o  = rsp_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_IFU;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
